// File: rtl/module_display_pkg.sv
// Shared types and constants for the BCD multiplexed display:
// FSM states, segment patterns, digit indices and double-dabble helpers.
package module_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  // Segment patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit scan indices
  localparam logic [1:0] DIG_UNITS    = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;

  // Active-low anode pattern for a digit index
  function automatic logic [2:0] anode_for(input logic [1:0] dig);
    logic [2:0] an;
    case (dig)
      DIG_UNITS:    an = 3'b110;
      DIG_TENS:     an = 3'b101;
      DIG_HUNDREDS: an = 3'b011;
      default:      an = 3'b110;
    endcase
    return an;
  endfunction

  // Double-dabble correction of one BCD nibble
  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // One double-dabble iteration on {hundreds, tens, units, binary}
  function automatic logic [19:0] dd_step(input logic [19:0] sh);
    logic [19:0] adj;
    adj = {dd_adjust(sh[19:16]), dd_adjust(sh[15:12]), dd_adjust(sh[11:8]), sh[7:0]};
    return {adj[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/module_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern, with blanking.
module module_seg7_decoder
  import module_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank overrides the digit; non-BCD codes show nothing
  always_comb begin
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/module_bcd_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a three-digit
// multiplexed seven-segment display with leading-zero blanking. Strobes that
// arrive while a conversion runs are held in a single pending slot.
module module_bcd_display
  import module_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_a,
  input  logic       load_b,
  input  logic       load_m,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [7:0] m,
  output logic [2:0] anodo,
  output logic [6:0] catodo,
  output logic       busy
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  state_e            state_q, state_d;
  logic [19:0]       sh_q, sh_d;         // {hundreds, tens, units, binary}
  logic [2:0]        bit_q, bit_d;
  logic              pend_flag_q, pend_flag_d;
  logic [7:0]        pend_val_q, pend_val_d;
  logic [11:0]       disp_q, disp_d;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        dig_q, dig_d;
  logic [2:0]        anodo_q;
  logic [6:0]        catodo_q;

  logic              strobe_s;
  logic [7:0]        sel_val_s;
  logic [3:0]        digit_val_s;
  logic              digit_blank_s;
  logic [6:0]        seg_s;

  // Strobe priority: m over b over a
  always_comb begin
    strobe_s  = load_a | load_b | load_m;
    sel_val_s = 8'd0;
    if (load_m) begin
      sel_val_s = m;
    end else if (load_b) begin
      sel_val_s = {4'b0000, b};
    end else if (load_a) begin
      sel_val_s = {4'b0000, a};
    end else begin
      sel_val_s = 8'd0;
    end
  end

  // Conversion FSM next-state, shift datapath, pending slot and display copy
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_d       = bit_q;
    pend_flag_d = pend_flag_q;
    pend_val_d  = pend_val_q;
    disp_d      = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (strobe_s) begin
          state_d = ST_SHIFT;
          sh_d    = {12'd0, sel_val_s};
          bit_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_d  = dd_step(sh_q);
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_SHIFT;
        end
        if (strobe_s) begin
          pend_flag_d = 1'b1;
          pend_val_d  = sel_val_s;
        end else begin
          pend_flag_d = pend_flag_q;
        end
      end
      ST_UPDATE: begin
        disp_d = sh_q[19:8];
        bit_d  = 3'd0;
        // A strobe in this very cycle is newer than anything pending
        if (strobe_s) begin
          state_d     = ST_SHIFT;
          sh_d        = {12'd0, sel_val_s};
          pend_flag_d = 1'b0;
        end else if (pend_flag_q) begin
          state_d     = ST_SHIFT;
          sh_d        = {12'd0, pend_val_q};
          pend_flag_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        pend_flag_d = 1'b0;
      end
    endcase
  end

  // Conversion state, pending slot, display registers and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= 20'd0;
      bit_q       <= 3'd0;
      pend_flag_q <= 1'b0;
      pend_val_q  <= 8'd0;
      disp_q      <= 12'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      pend_flag_q <= pend_flag_d;
      pend_val_q  <= pend_val_d;
      disp_q      <= disp_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Refresh divider and digit scan sequence
  always_comb begin
    cnt_d = cnt_q;
    dig_d = dig_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      case (dig_q)
        DIG_UNITS:    dig_d = DIG_TENS;
        DIG_TENS:     dig_d = DIG_HUNDREDS;
        DIG_HUNDREDS: dig_d = DIG_UNITS;
        default:      dig_d = DIG_UNITS;
      endcase
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Select the scanned digit and its leading-zero blanking
  always_comb begin
    digit_val_s   = 4'd0;
    digit_blank_s = 1'b0;
    case (dig_q)
      DIG_UNITS: begin
        digit_val_s   = disp_q[3:0];
        digit_blank_s = 1'b0;
      end
      DIG_TENS: begin
        digit_val_s   = disp_q[7:4];
        digit_blank_s = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
      end
      DIG_HUNDREDS: begin
        digit_val_s   = disp_q[11:8];
        digit_blank_s = (disp_q[11:8] == 4'd0);
      end
      default: begin
        digit_val_s   = 4'd0;
        digit_blank_s = 1'b1;
      end
    endcase
  end

  module_seg7_decoder u_seg7 (
    .bcd_i   (digit_val_s),
    .blank_i (digit_blank_s),
    .seg_o   (seg_s)
  );

  // Scan counters and registered display outputs, anode and cathode together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      dig_q    <= DIG_UNITS;
      anodo_q  <= 3'b110;
      catodo_q <= SEG_0;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      anodo_q  <= anode_for(dig_q);
      catodo_q <= seg_s;
    end
  end

  assign anodo  = anodo_q;
  assign catodo = catodo_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_module_bcd_display.sv
// Scoreboard bench: stimulus pushes expected display contents with the cycle
// they take effect; a negedge monitor checks every scanned digit against the
// current expectation and checks the anode scan sequence and hold time.
module tb_module_bcd_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_a, load_b, load_m;
  logic [3:0] a, b;
  logic [7:0] m;
  logic [2:0] anodo;
  logic [6:0] catodo;
  logic       busy;

  module_bcd_display #(.REFRESH_DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .load_a (load_a),
    .load_b (load_b),
    .load_m (load_m),
    .a      (a),
    .b      (b),
    .m      (m),
    .anodo  (anodo),
    .catodo (catodo),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000,
                         P8 = 7'b0000000, P9 = 7'b0010000, PB = 7'b1111111;

  typedef struct {
    int         at;
    bit         care;
    logic [6:0] u;
    logic [6:0] t;
    logic [6:0] h;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  bit   cur_valid = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] prev_an = 3'b110;
  int         run = 0;
  bit         first_run = 1'b1;

  // Edge counter: value seen just after posedge k is k
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] next_an(input logic [2:0] an);
    logic [2:0] r;
    case (an)
      3'b110:  r = 3'b101;
      3'b101:  r = 3'b011;
      default: r = 3'b110;
    endcase
    return r;
  endfunction

  // Monitor: scan sequence, hold time and per-digit segment contents
  always @(negedge clk) begin
    if (rst) begin
      first_run = 1'b1;
      run       = 0;
      prev_an   = 3'b110;
    end else begin
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
        cur       = sbq.pop_front();
        cur_valid = 1'b1;
      end
      n_cmp++;
      if (!(anodo == 3'b110 || anodo == 3'b101 || anodo == 3'b011)) begin
        n_bad++;
        $display("FAIL onehot cyc=%0d anodo=%b", cyc, anodo);
      end
      if (anodo == prev_an) begin
        run++;
      end else begin
        n_cmp++;
        if (anodo != next_an(prev_an)) begin
          n_bad++;
          $display("FAIL scan_order cyc=%0d anodo=%b expected %b", cyc, anodo, next_an(prev_an));
        end
        if (!first_run) begin
          n_cmp++;
          if (run != 4) begin
            n_bad++;
            $display("FAIL hold_time cyc=%0d held=%0d expected 4", cyc, run);
          end
        end
        first_run = 1'b0;
        run       = 1;
        prev_an   = anodo;
      end
      if (cur_valid && cur.care) begin
        logic [6:0] e;
        e = PB;
        case (anodo)
          3'b110:  e = cur.u;
          3'b101:  e = cur.t;
          3'b011:  e = cur.h;
          default: e = 7'bxxxxxxx;
        endcase
        if (anodo == 3'b110 || anodo == 3'b101 || anodo == 3'b011) begin
          n_cmp++;
          if (catodo !== e) begin
            n_bad++;
            $display("FAIL segments cyc=%0d anodo=%b catodo=%b expected %b", cyc, anodo, catodo, e);
          end
        end
      end
    end
  end

  // Pulse the chosen strobes so they are sampled at edge >= at_edge; returns the edge
  task automatic strobe(input bit la, input bit lb, input bit lm,
                        input logic [3:0] av, input logic [3:0] bv, input logic [7:0] mv,
                        input int at_edge, output int n);
    @(posedge clk); #1;
    while (cyc + 1 < at_edge) begin
      @(posedge clk); #1;
    end
    load_a = la; load_b = lb; load_m = lm;
    a = av; b = bv; m = mv;
    n = cyc + 1;
    @(posedge clk); #1;
    load_a = 1'b0; load_b = 1'b0; load_m = 1'b0;
  endtask

  task automatic push_exp(input int at, input bit care,
                          input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
    exp_t e;
    e.at = at; e.care = care; e.u = u; e.t = t; e.h = h;
    sbq.push_back(e);
  endtask

  task automatic wait_idle_and_scan(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL %s_idle_timeout busy=%b expected 0", tag, busy);
    end
    repeat (14) @(negedge clk);
  endtask

  task automatic convert(input bit la, input bit lb, input bit lm,
                         input logic [3:0] av, input logic [3:0] bv, input logic [7:0] mv,
                         input logic [6:0] u, input logic [6:0] t, input logic [6:0] h,
                         input string tag);
    int n;
    strobe(la, lb, lm, av, bv, mv, 0, n);
    push_exp(n + 10, 1'b1, u, t, h);
    wait_idle_and_scan(tag);
  endtask

  initial begin
    int n, nb, hi;
    rst = 1'b1;
    load_a = 1'b0; load_b = 1'b0; load_m = 1'b0;
    a = 4'd0; b = 4'd0; m = 8'd0;
    #1;
    n_cmp += 3;
    if (anodo !== 3'b110)  begin n_bad++; $display("FAIL reset_anodo got %b expected 110", anodo); end
    if (catodo !== P0)     begin n_bad++; $display("FAIL reset_catodo got %b expected %b", catodo, P0); end
    if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b expected 0", busy); end
    push_exp(0, 1'b1, P0, PB, PB);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // m=225: busy length, then 2/2/5
    strobe(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'd225, 0, n);
    push_exp(n + 10, 1'b1, P5, P2, P2);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) hi++;
    end
    n_cmp++;
    if (hi != 9) begin n_bad++; $display("FAIL busy_len got %0d expected 9", hi); end
    wait_idle_and_scan("m225");

    convert(1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 8'd0,   P7, PB, PB, "a7");
    convert(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'd0,   P0, PB, PB, "m0");
    convert(1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 8'd108, P8, P0, P1, "a3_m108");
    convert(1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 8'd0,  P5, P1, PB, "b15");
    convert(1'b1, 1'b1, 1'b0, 4'd2, 4'd6, 8'd0,   P6, PB, PB, "a2_b6");
    convert(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'd255, P5, P5, P2, "m255");
    convert(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'd100, P0, P0, P1, "m100");

    // m=99, then b=5 and a=9 while busy: 99, then 9; 5 must never appear
    strobe(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'd99, 0, n);
    push_exp(n + 10, 1'b1, P9, P9, PB);
    push_exp(n + 19, 1'b0, PB, PB, PB);
    push_exp(n + 20, 1'b1, P9, PB, PB);
    strobe(1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 8'd0, n + 3, nb);
    strobe(1'b1, 1'b0, 1'b0, 4'd9, 4'd0, 8'd0, n + 5, nb);
    while (cyc < n + 12) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL pending_busy got %b expected 1", busy); end
    wait_idle_and_scan("pending");

    // m=200 aborted by asynchronous reset mid-conversion
    strobe(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'd200, 0, n);
    while (cyc < n + 4) begin @(posedge clk); end
    #2 rst = 1'b1;
    #1;
    n_cmp += 3;
    if (anodo !== 3'b110) begin n_bad++; $display("FAIL abort_anodo got %b expected 110", anodo); end
    if (catodo !== P0)    begin n_bad++; $display("FAIL abort_catodo got %b expected %b", catodo, P0); end
    if (busy !== 1'b0)    begin n_bad++; $display("FAIL abort_busy got %b expected 0", busy); end
    sbq.delete();
    push_exp(0, 1'b1, P0, PB, PB);
    @(posedge clk);
    #1 rst = 1'b0;
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) hi++;
    end
    n_cmp++;
    if (hi != 0) begin n_bad++; $display("FAIL abort_no_resume busy_cycles=%0d expected 0", hi); end
    repeat (8) @(negedge clk);

    n_cmp++;
    if (sbq.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain left=%0d expected 0", sbq.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
